interrupt_ctrl: RTL and testbench

INTERRUPT_CTRL -- requirements
Module: interrupt_ctrl

---
 rtl/interrupt_ctrl.sv | 153 +++++++++++++++
 tb/tb_interrupt_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/interrupt_ctrl.sv
// Interrupt controller: IF/IE registers, fixed-priority arbitration and a
// three-state offer/dispatch FSM.
// Optional feature macro: INTR_EI_DELAY_EN. When defined, EI arms a pending
// flag and IME rises on the edge after the next instr_done pulse.
module interrupt_ctrl #(
  parameter int DISPATCH_CYCLES = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] src_req,
  input  logic       reg_sel,
  input  logic       reg_wr,
  input  logic [7:0] reg_wdata,
  output logic [7:0] reg_rdata,
  input  logic       ime_set,
  input  logic       ime_clr,
  input  logic       reti,
  input  logic       instr_done,
  output logic       irq_valid,
  output logic [7:0] irq_vector,
  input  logic       irq_ack,
  output logic       irq_busy,
  output logic       wake
);

  typedef enum logic [1:0] {IDLE, PEND, DISPATCH} state_e;

  localparam logic [3:0] CNT_LOAD = 4'(DISPATCH_CYCLES - 1);

  state_e     state_q, state_d;
  logic [4:0] if_q, if_d;
  logic [7:0] ie_q, ie_d;
  logic       ime_q, ime_d;
  logic       ei_pend_q, ei_pend_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] vec_q, vec_d;

  logic [4:0] pend_w;
  logic [4:0] win_oh;
  logic [2:0] win_idx;
  logic [7:0] cur_vec;
  logic       any_pend;
  logic       ack_fire;

  assign pend_w   = ie_q[4:0] & if_q;
  assign any_pend = |pend_w;
  assign wake     = any_pend;
  assign cur_vec  = 8'h40 + {2'b00, win_idx, 3'b000};

  // Lowest set bit wins; scan high to low so the last hit is the lowest index.
  always_comb begin
    win_idx = 3'd0;
    win_oh  = '0;
    for (int i = 4; i >= 0; i--) begin
      if (pend_w[i]) begin
        win_idx   = 3'(i);
        win_oh    = '0;
        win_oh[i] = 1'b1;
      end
    end
  end

  // Offer is qualified by the live IME/pending state so a DI or a cleared
  // source drops irq_valid in the same cycle the register changes.
  assign irq_valid  = (state_q == PEND) && ime_q && any_pend;
  assign irq_vector = (state_q == PEND) ? cur_vec : vec_q;
  assign irq_busy   = (state_q == DISPATCH);
  assign ack_fire   = irq_valid && irq_ack;
  assign reg_rdata  = reg_sel ? ie_q : {3'b111, if_q};

  // IF/IE next state: software write first, ack clears the winner, then
  // hardware requests are ORed in so they always win.
  always_comb begin
    if_d = if_q;
    ie_d = ie_q;
    if (reg_wr && !reg_sel) if_d = reg_wdata[4:0];
    if (reg_wr &&  reg_sel) ie_d = reg_wdata;
    if (ack_fire)           if_d = if_d & ~win_oh;
    if_d = if_d | src_req;
  end

  // IME / pending-EI next state. Ack and DI dominate; RETI is always immediate.
  always_comb begin
    ime_d     = ime_q;
    ei_pend_d = ei_pend_q;
`ifdef INTR_EI_DELAY_EN
    if (ei_pend_q && instr_done) begin
      ime_d     = 1'b1;
      ei_pend_d = 1'b0;
    end
    if (ime_set) ei_pend_d = 1'b1;
`else
    if (ime_set) ime_d = 1'b1;
`endif
    if (reti) ime_d = 1'b1;
    if (ime_clr || ack_fire) begin
      ime_d     = 1'b0;
      ei_pend_d = 1'b0;
    end
  end

`ifndef INTR_EI_DELAY_EN
  // instr_done and the EI-pending flag have no function in this build.
  logic unused_sink;
  assign unused_sink = instr_done ^ ei_pend_q;
`endif

  // FSM next state, dispatch counter and latched vector.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    vec_d   = vec_q;
    case (state_q)
      IDLE: if (ime_q && any_pend) state_d = PEND;
      PEND: begin
        if (ack_fire) begin
          state_d = DISPATCH;
          cnt_d   = CNT_LOAD;
          vec_d   = cur_vec;
        end else if (!ime_q || !any_pend) begin
          state_d = IDLE;
        end
      end
      DISPATCH: begin
        if (cnt_q == 4'd0) state_d = IDLE;
        else               cnt_d   = cnt_q - 4'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      if_q      <= '0;
      ie_q      <= '0;
      ime_q     <= 1'b0;
      ei_pend_q <= 1'b0;
      cnt_q     <= '0;
      vec_q     <= '0;
    end else begin
      state_q   <= state_d;
      if_q      <= if_d;
      ie_q      <= ie_d;
      ime_q     <= ime_d;
      ei_pend_q <= ei_pend_d;
      cnt_q     <= cnt_d;
      vec_q     <= vec_d;
    end
  end

endmodule

// File: tb/tb_interrupt_ctrl.sv
// Self-checking bench for interrupt_ctrl; expected vectors are queued when
// the triggering stimulus is driven and popped when the offer appears.
module tb_interrupt_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] src_req = '0;
  logic       reg_sel = 1'b0;
  logic       reg_wr = 1'b0;
  logic [7:0] reg_wdata = '0;
  logic [7:0] reg_rdata;
  logic       ime_set = 1'b0;
  logic       ime_clr = 1'b0;
  logic       reti = 1'b0;
  logic       instr_done = 1'b0;
  logic       irq_valid;
  logic [7:0] irq_vector;
  logic       irq_ack = 1'b0;
  logic       irq_busy;
  logic       wake;

  int pass_cnt = 0;
  int total = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_v;

  interrupt_ctrl #(.DISPATCH_CYCLES(5)) dut (
    .clk(clk), .rst_n(rst_n), .src_req(src_req), .reg_sel(reg_sel),
    .reg_wr(reg_wr), .reg_wdata(reg_wdata), .reg_rdata(reg_rdata),
    .ime_set(ime_set), .ime_clr(ime_clr), .reti(reti),
    .instr_done(instr_done), .irq_valid(irq_valid), .irq_vector(irq_vector),
    .irq_ack(irq_ack), .irq_busy(irq_busy), .wake(wake)
  );

  always #5 clk = ~clk;

  // Advance one edge; inputs change and outputs are sampled 1 time unit later.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc();
    cyc();
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic wr(input logic sel, input logic [7:0] d);
    reg_sel = sel; reg_wr = 1'b1; reg_wdata = d;
    cyc();
    reg_wr = 1'b0; reg_sel = 1'b0;
  endtask

  task automatic pulse_reti();
    reti = 1'b1; cyc(); reti = 1'b0;
  endtask

  task automatic wait_valid(output logic ok);
    ok = 1'b0;
    for (int n = 0; n < 20; n++) begin
      if (irq_valid) begin ok = 1'b1; break; end
      cyc();
    end
  endtask

  task automatic ack_and_count(output int n);
    irq_ack = 1'b1; cyc(); irq_ack = 1'b0;
    n = 0;
    while (irq_busy && n < 30) begin n++; cyc(); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    total++; if ({irq_valid, irq_busy, wake} !== 3'b000) $display("FAIL reset_flags got %b want 000", {irq_valid, irq_busy, wake}); else pass_cnt++;
    total++; if (irq_vector !== 8'h00) $display("FAIL reset_vector got %h want 00", irq_vector); else pass_cnt++;
    reg_sel = 1'b0; #1;
    total++; if (reg_rdata !== 8'hE0) $display("FAIL reset_if got %h want e0", reg_rdata); else pass_cnt++;
    reg_sel = 1'b1; #1;
    total++; if (reg_rdata !== 8'h00) $display("FAIL reset_ie got %h want 00", reg_rdata); else pass_cnt++;
    reg_sel = 1'b0;
    do_reset();
  endtask

  task automatic test_single();
    int n;
    do_reset();
    // Ack in IDLE must be ignored.
    irq_ack = 1'b1; cyc(); irq_ack = 1'b0;
    total++; if (irq_busy !== 1'b0) $display("FAIL ack_idle busy got %b want 0", irq_busy); else pass_cnt++;
    wr(1'b1, 8'h04);
    pulse_reti();
    src_req = 5'b00100; exp_q.push_back(8'h50);
    cyc(); src_req = '0;
    cyc();
    exp_v = exp_q.pop_front();
    total++; if (irq_valid !== 1'b1 || irq_vector !== exp_v) $display("FAIL single_offer got %b/%h want 1/%h", irq_valid, irq_vector, exp_v); else pass_cnt++;
    ack_and_count(n);
    total++; if (n !== 5) $display("FAIL single_busy_len got %0d want 5", n); else pass_cnt++;
    reg_sel = 1'b0; #1;
    total++; if (reg_rdata !== 8'hE0) $display("FAIL single_if_clr got %h want e0", reg_rdata); else pass_cnt++;
  endtask

  task automatic test_priority();
    logic ok;
    int n;
    do_reset();
    wr(1'b1, 8'h1F);
    wr(1'b0, 8'h1F);
    for (int i = 0; i < 5; i++) exp_q.push_back(8'h40 + 8'(8 * i));
    pulse_reti();
    for (int i = 0; i < 5; i++) begin
      wait_valid(ok);
      exp_v = exp_q.pop_front();
      total++; if (!ok || irq_vector !== exp_v) $display("FAIL prio_vec%0d got %b/%h want 1/%h", i, ok, irq_vector, exp_v); else pass_cnt++;
      ack_and_count(n);
      total++; if (n !== 5) $display("FAIL prio_busy%0d got %0d want 5", i, n); else pass_cnt++;
      pulse_reti();
    end
    total++; if (reg_rdata !== 8'hE0) $display("FAIL prio_if_end got %h want e0", reg_rdata); else pass_cnt++;
  endtask

  task automatic test_preempt();
    logic ok;
    int n;
    do_reset();
    wr(1'b1, 8'h1F);
    wr(1'b0, 8'h08);
    exp_q.push_back(8'h58);
    pulse_reti();
    wait_valid(ok);
    exp_v = exp_q.pop_front();
    total++; if (!ok || irq_vector !== exp_v) $display("FAIL preempt_first got %b/%h want 1/%h", ok, irq_vector, exp_v); else pass_cnt++;
    src_req = 5'b00001; exp_q.push_back(8'h40);
    cyc(); src_req = '0;
    exp_v = exp_q.pop_front();
    total++; if (irq_valid !== 1'b1 || irq_vector !== exp_v) $display("FAIL preempt_vec got %b/%h want 1/%h", irq_valid, irq_vector, exp_v); else pass_cnt++;
    // Ack while the same source requests again: bit0 stays set.
    src_req = 5'b00001;
    ack_and_count(n);
    src_req = '0;
    reg_sel = 1'b0; #1;
    total++; if (reg_rdata !== 8'hE9) $display("FAIL ack_race_if got %h want e9", reg_rdata); else pass_cnt++;
  endtask

  task automatic test_reg_access();
    do_reset();
    reg_sel = 1'b0; reg_wr = 1'b1; reg_wdata = 8'h00; src_req = 5'b00010;
    cyc();
    reg_wr = 1'b0; src_req = '0; #1;
    total++; if (reg_rdata !== 8'hE2) $display("FAIL if_wr_race got %h want e2", reg_rdata); else pass_cnt++;
    wr(1'b1, 8'hA5);
    reg_sel = 1'b1; #1;
    total++; if (reg_rdata !== 8'hA5) $display("FAIL ie_rdback got %h want a5", reg_rdata); else pass_cnt++;
    reg_sel = 1'b0;
  endtask

  task automatic test_ime_clr();
    logic ok;
    do_reset();
    wr(1'b1, 8'h01);
    wr(1'b0, 8'h01);
    pulse_reti();
    wait_valid(ok);
    total++; if (!ok) $display("FAIL clr_offer got 0 want 1"); else pass_cnt++;
    ime_clr = 1'b1; cyc(); ime_clr = 1'b0;
    total++; if (irq_valid !== 1'b0) $display("FAIL clr_valid got %b want 0", irq_valid); else pass_cnt++;
    cyc(); cyc();
    total++; if ({irq_valid, irq_busy} !== 2'b00) $display("FAIL clr_idle got %b want 00", {irq_valid, irq_busy}); else pass_cnt++;
    total++; if (reg_rdata !== 8'hE1 || wake !== 1'b1) $display("FAIL clr_if_wake got %h/%b want e1/1", reg_rdata, wake); else pass_cnt++;
  endtask

  task automatic test_reset_mid_dispatch();
    logic ok;
    int n;
    do_reset();
    wr(1'b1, 8'h04);
    pulse_reti();
    src_req = 5'b00100; cyc(); src_req = '0;
    wait_valid(ok);
    irq_ack = 1'b1; cyc(); irq_ack = 1'b0;
    cyc();
    rst_n = 1'b0; #1;
    total++; if ({irq_busy, irq_valid} !== 2'b00 || reg_rdata !== 8'hE0) $display("FAIL rst_mid got %b/%h want 00/e0", {irq_busy, irq_valid}, reg_rdata); else pass_cnt++;
    cyc();
    rst_n = 1'b1;
    cyc();
    n = 0;
    total++; if (irq_busy !== 1'b0 || ok !== 1'b1) $display("FAIL rst_mid_after got %b/%b want 0/1", irq_busy, ok); else pass_cnt++;
  endtask

  task automatic test_ei();
    do_reset();
    wr(1'b1, 8'h01);
    wr(1'b0, 8'h01);
    // DI wins over EI in the same cycle.
    ime_set = 1'b1; ime_clr = 1'b1; cyc(); ime_set = 1'b0; ime_clr = 1'b0;
    instr_done = 1'b1; cyc(); instr_done = 1'b0;
    cyc(); cyc();
    total++; if (irq_valid !== 1'b0) $display("FAIL ei_clr_wins got %b want 0", irq_valid); else pass_cnt++;
    ime_set = 1'b1; cyc(); ime_set = 1'b0;
`ifdef INTR_EI_DELAY_EN
    cyc(); cyc();
    total++; if (irq_valid !== 1'b0) $display("FAIL ei_delay_hold got %b want 0", irq_valid); else pass_cnt++;
    instr_done = 1'b1; cyc(); instr_done = 1'b0;
    total++; if (irq_valid !== 1'b0) $display("FAIL ei_delay_edge got %b want 0", irq_valid); else pass_cnt++;
    cyc();
    total++; if (irq_valid !== 1'b1) $display("FAIL ei_delay_on got %b want 1", irq_valid); else pass_cnt++;
`else
    total++; if (irq_valid !== 1'b0) $display("FAIL ei_fast_pre got %b want 0", irq_valid); else pass_cnt++;
    cyc();
    total++; if (irq_valid !== 1'b1) $display("FAIL ei_fast_on got %b want 1", irq_valid); else pass_cnt++;
`endif
  endtask

  initial begin
    test_reset();
    test_single();
    test_priority();
    test_preempt();
    test_reg_access();
    test_ime_clr();
    test_reset_mid_dispatch();
    test_ei();
    total++; if (exp_q.size() !== 0) $display("FAIL scoreboard_left got %0d want 0", exp_q.size()); else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
